// File: rtl/buffer_read_arbiter.sv
// buffer_read_arbiter: round-robin arbiter sharing one indexed-buffer read port among NUM_REQ requesters
module buffer_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_index,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [7:0]                    rsp_data,
  output logic                          rsp_err,
  output logic                          buf_read_en,
  output logic [ADDR_WIDTH-1:0]         buf_read_index,
  input  logic [7:0]                    buf_read_data,
  input  logic [ADDR_WIDTH:0]           buf_count,
  output logic                          busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t                r_state;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_gnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_err;
  logic [IW-1:0]         w_gnt;
  logic                  w_any;
  logic                  w_in_range;
  logic                  w_grant;
  // Descending scan so the nearest requester after r_last is written last and wins.
  always_comb begin
    w_gnt = r_last;
    for (int k = NUM_REQ; k > 0; k--)
      if (req_valid[(int'(r_last) + k) % NUM_REQ]) w_gnt = IW'((int'(r_last) + k) % NUM_REQ);
  end
  assign w_any      = |req_valid;
  assign w_grant    = !rst && r_state == IDLE && w_any;
  assign w_in_range = ({1'b0, r_idx} < buf_count) && (int'(r_idx) < DEPTH);
  assign req_ready      = w_grant ? NUM_REQ'(1) << w_gnt : '0;
  assign buf_read_en    = !rst && r_state == READ && w_in_range;
  assign buf_read_index = buf_read_en ? r_idx : '0;
  assign rsp_valid      = (!rst && r_state == RESP) ? NUM_REQ'(1) << r_gnt : '0;
  assign rsp_err        = !rst && r_state == RESP && r_err;
  assign rsp_data       = (!rst && r_state == RESP && !r_err) ? buf_read_data : 8'h00;
  assign busy           = !rst && r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_gnt   <= w_gnt;
      r_last  <= w_gnt;
      r_idx   <= req_index[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
      r_state <= READ;
    end else if (r_state == READ) begin
      r_err   <= !w_in_range;
      r_state <= RESP;
    end else if (r_state == RESP) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_buffer_read_arbiter.sv
// tb_buffer_read_arbiter: directed stimulus with a response scoreboard and a small indexed-buffer model
module tb_buffer_read_arbiter;
  localparam int N = 4;
  localparam int AW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_index = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_err, buf_read_en, busy;
  logic [AW-1:0] buf_read_index;
  logic [7:0]    buf_read_data = '0;
  logic [AW:0]   cnt = '0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic [7:0]    mem [512];
  typedef struct {int g; logic [7:0] d; logic e;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  buffer_read_arbiter #(.NUM_REQ(N), .DEPTH(256), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .buf_read_en(buf_read_en), .buf_read_index(buf_read_index), .buf_read_data(buf_read_data),
    .buf_count(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Index 0 is the newest sample; read data registers one edge after buf_read_en.
  always @(posedge clk) begin
    if (buf_read_en) buf_read_data <= mem[9'(cnt - 9'd1 - {1'b0, buf_read_index})];
    if (wr_en) begin
      mem[cnt] <= wr_data;
      cnt <= cnt + 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.g);
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic issue(input int g, input logic [7:0] idx);
    @(posedge clk); #1;
    req_valid = N'(1) << g;
    req_index[g*AW +: AW] = idx;
  endtask

  // Starts in the expected grant cycle, returns at the negedge of the RESP cycle.
  task automatic txn(input int g, input logic [7:0] idx, input logic [7:0] d, input logic e,
                     input logic hold, input logic wr_in_read);
    exp_t x;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(1) << g);
    chk("busy_idle", 32'(busy), 32'h0);
    x.g = g; x.d = d; x.e = e;
    exp_q.push_back(x);
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    if (wr_in_read) begin
      wr_en = 1'b1;
      wr_data = 8'h66;
    end
    @(negedge clk);
    chk("buf_read_en", 32'(buf_read_en), 32'(!e));
    if (!e) chk("buf_read_index", 32'(buf_read_index), 32'(idx));
    chk("ready_in_read", 32'(req_ready), 32'h0);
    chk("busy_read", 32'(busy), 32'h1);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("busy_resp", 32'(busy), 32'h1);
    chk("rd_en_resp", 32'(buf_read_en), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_buf_read_en", 32'(buf_read_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    // Empty buffer always errors.
    issue(1, 8'd0);
    txn(1, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    wr(8'h11); wr(8'h22); wr(8'h33);
    issue(0, 8'd0);
    txn(0, 8'd0, 8'h33, 1'b0, 1'b0, 1'b0);
    issue(2, 8'd3);
    txn(2, 8'd3, 8'h00, 1'b1, 1'b0, 1'b0);
    issue(3, 8'd1);
    txn(3, 8'd1, 8'h22, 1'b0, 1'b0, 1'b0);
    issue(1, 8'd2);
    txn(1, 8'd2, 8'h11, 1'b0, 1'b0, 1'b0);
    // Round-robin from reset with all requesters held.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_index[i*AW +: AW] = AW'(i);
    txn(0, 8'd0, 8'h33, 1'b0, 1'b1, 1'b0);
    txn(1, 8'd1, 8'h22, 1'b0, 1'b1, 1'b0);
    txn(2, 8'd2, 8'h11, 1'b0, 1'b1, 1'b0);
    txn(3, 8'd3, 8'h00, 1'b1, 1'b1, 1'b0);
    txn(0, 8'd0, 8'h33, 1'b0, 1'b0, 1'b0);
    // Reset during READ abandons the transaction and restores requester 0 priority.
    issue(2, 8'd0);
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("abort_busy_in_rst", 32'(busy), 32'h0);
    chk("abort_rd_en_in_rst", 32'(buf_read_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b1001;
    req_index[0 +: AW] = 8'd0;
    req_index[3*AW +: AW] = 8'd0;
    txn(0, 8'd0, 8'h33, 1'b0, 1'b0, 1'b0);
    // Write lands on the same edge that registers the read.
    wr(8'h44); wr(8'h55);
    issue(1, 8'd4);
    txn(1, 8'd4, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("count_after_wr", 32'(cnt), 32'd6);
    issue(2, 8'd6);
    txn(2, 8'd6, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/buffer_read_arbiter.md
BUFFER_READ_ARBITER -- requirements
Module: buffer_read_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4: number of read requesters.
- DEPTH, default 256: depth of the indexed buffer.
- ADDR_WIDTH, default 8: buffer index width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester read request.
- req_index  in  NUM_REQ*ADDR_WIDTH  per-requester index; slice i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]; 0 = newest sample.
- req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot; response strobe to the owning requester.
- rsp_data  out  8  response byte; shared by all requesters.
- rsp_err  out  1  response is out-of-range; qualified by rsp_valid.
- buf_read_en  out  1  read strobe to the indexed buffer.
- buf_read_index  out  ADDR_WIDTH  index to the buffer.
- buf_read_data  in  8  buffer registered read data; valid the cycle after buf_read_en.
- buf_count  in  ADDR_WIDTH+1  buffer occupancy.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, READ and RESP.
REQ-004 In IDLE with any req_valid high, the block SHALL grant exactly one requester using round-robin arbitration, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-005 In the grant cycle T, req_ready[g] SHALL be high combinationally for the granted requester g only. The block SHALL latch g and req_index slice g, update last_grant to g, and move to READ.
REQ-006 req_ready SHALL be all-zero in every cycle that is not an IDLE grant cycle. req_valid during READ or RESP SHALL be ignored, not lost; the requester holds it.
REQ-007 In READ (cycle T+1):
- If latched index < buf_count, buf_read_en SHALL be 1 and buf_read_index SHALL equal the latched index.
- Otherwise buf_read_en SHALL be 0 and an error flag SHALL be latched.
- The next state SHALL be RESP in both cases.
REQ-008 The index compare SHALL be unsigned, with the index zero-extended to ADDR_WIDTH+1 bits. An empty buffer (buf_count=0) SHALL therefore always produce an error.
REQ-009 In RESP (cycle T+2):
- rsp_valid[g] SHALL be 1 for exactly one cycle.
- rsp_data SHALL equal buf_read_data, or 0 on error.
- rsp_err SHALL equal the error flag.
- The next state SHALL be IDLE.
REQ-010 Request-to-response latency SHALL be exactly 2 cycles. Maximum throughput SHALL be one request per 3 cycles; a new grant is allowed in the cycle after RESP.
REQ-011 Responses SHALL have no backpressure; the requester must accept rsp_valid.
REQ-012 Outside RESP, rsp_valid SHALL be 0 and rsp_data/rsp_err SHALL be 0. Outside READ, buf_read_en SHALL be 0 and buf_read_index SHALL be 0.
REQ-013 The block SHALL never drive the buffer write port; writes to the buffer concurrent with READ are allowed. buf_count is sampled in the READ cycle only.
REQ-014 busy SHALL be 1 in READ and RESP, and 0 in IDLE.

Reset
REQ-015 On rst=1 at a clock edge, the block SHALL set:
- state = IDLE.
- last_grant = NUM_REQ-1, so requester 0 has first priority.
- latched index, requester id and error flag = 0.
REQ-016 While rst=1, all outputs SHALL be 0.
REQ-017 A reset in READ or RESP SHALL abandon the transaction with no rsp_valid issued. The first grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-018 Single request, buffer written 0x11,0x22,0x33 (count=3), req_valid[0]=1, index=0:
-> req_ready[0] at T, buf_read_en=1 with index 0 at T+1, rsp_valid[0]=1, rsp_data=0x33, rsp_err=0 at T+2.
REQ-019 Out-of-range, count=3, req_valid[2]=1, index=3:
-> buf_read_en stays 0, rsp_valid[2]=1, rsp_err=1, rsp_data=0x00 at T+2.
REQ-020 Round-robin, after reset all four req_valid held high:
-> grants 0,1,2,3,0 at cycles 0,3,6,9,12.
-> each rsp_valid one-hot, matching its grant.
REQ-021 Empty buffer after reset, req_valid[1]=1, index=0:
-> rsp_err=1 at T+2.
REQ-022 Reset mid-transaction, rst=1 in the READ cycle:
-> no rsp_valid in any later cycle.
-> busy=0 on the next cycle.
-> requester 0 wins the first grant after release.
REQ-023 Concurrent write during READ, count=5, index=4:
-> rsp_data equals the byte the buffer registers for index 4 at that edge.
-> rsp_err=0.
